// File: rtl/wt_dcache_wbuf_coalesce_if.sv
// Store-side, memory-side and load-probe signals of the coalescing write buffer.
// slave = the buffer itself, master = whoever drives stores/loads and models memory.
interface wt_dcache_wbuf_coalesce_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              st_valid_i;
   logic              st_ready_o;
   logic [ADDR_W-1:0] st_addr_i;
   logic [DATA_W-1:0] st_data_i;
   logic [BE_W-1:0]   st_be_i;
   logic              mem_valid_o;
   logic              mem_ready_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic [BE_W-1:0]   mem_be_o;
   logic [ADDR_W-1:0] ld_addr_i;
   logic              ld_hit_o;
   logic              flush_i;
   logic              flush_done_o;
   logic [CNT_W-1:0]  count_o;

   modport slave (
      input  st_valid_i, st_addr_i, st_data_i, st_be_i, mem_ready_i, ld_addr_i, flush_i,
      output st_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, ld_hit_o,
             flush_done_o, count_o
   );

   modport master (
      output st_valid_i, st_addr_i, st_data_i, st_be_i, mem_ready_i, ld_addr_i, flush_i,
      input  st_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, ld_hit_o,
             flush_done_o, count_o
   );
endinterface

// File: rtl/wt_dcache_wbuf_coalesce.sv
// Write-through dcache write buffer: circular FIFO of word entries with byte coalescing,
// threshold / idle-timeout / flush draining and a load address-match probe.
module wt_dcache_wbuf_coalesce #(
   parameter int DEPTH        = 4,
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 32,
   parameter int COALESCE_EN  = 1,
   parameter int DRAIN_THRESH = 2,
   parameter int IDLE_TIMEOUT = 8
) (
   input logic                      clk_i,
   input logic                      rst_ni,
   wt_dcache_wbuf_coalesce_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int WA_W  = ADDR_W - OFF_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, REQ} state_e;

   state_e                       state_q;
   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][WA_W-1:0]   wa_q, wa_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [DEPTH-1:0][BE_W-1:0]   be_q, be_d;
   logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [TMR_W-1:0]             timer_q, timer_d;
   logic                         mem_valid_q;
   logic [ADDR_W-1:0]            mem_addr_q;
   logic [DATA_W-1:0]            mem_data_q;
   logic [BE_W-1:0]              mem_be_q;

   logic [WA_W-1:0]  st_wa, ld_wa;
   logic [DEPTH-1:0] st_match, ld_match;
   logic             hit, st_ready, acc, alloc, fire, drain_cond;
   logic             unused_lo;

   assign st_wa     = bus.st_addr_i[ADDR_W-1:OFF_W];
   assign ld_wa     = bus.ld_addr_i[ADDR_W-1:OFF_W];
   assign unused_lo = ^{bus.st_addr_i[OFF_W-1:0], bus.ld_addr_i[OFF_W-1:0]};

   // The head being offered to memory is locked so mem_* never changes under a stall.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign st_match[i] = vld_q[i] && (wa_q[i] == st_wa) &&
                           !(state_q == REQ && head_q == PTR_W'(i));
      assign ld_match[i] = vld_q[i] && (wa_q[i] == ld_wa);
   end

   assign hit      = (COALESCE_EN != 0) && (|st_match);
   assign st_ready = !bus.flush_i && (hit || count_q != CNT_W'(DEPTH));
   assign acc      = bus.st_valid_i && st_ready;
   assign alloc    = acc && !hit;
   assign fire     = mem_valid_q && bus.mem_ready_i;

   always_comb begin
      vld_d   = vld_q;
      wa_d    = wa_q;
      data_d  = data_q;
      be_d    = be_q;
      head_d  = head_q;
      tail_d  = tail_q;
      timer_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (acc && hit && st_match[i]) begin
            for (int b = 0; b < BE_W; b++)
               if (bus.st_be_i[b]) data_d[i][b*8 +: 8] = bus.st_data_i[b*8 +: 8];
            be_d[i] = be_q[i] | bus.st_be_i;
         end
      end
      if (alloc) begin
         vld_d[tail_q]  = 1'b1;
         wa_d[tail_q]   = st_wa;
         data_d[tail_q] = bus.st_data_i;
         be_d[tail_q]   = bus.st_be_i;
         tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
      end
      if (fire) begin
         vld_d[head_q] = 1'b0;
         head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(fire);
      if (!acc && count_q != '0)
         timer_d = (timer_q == TMR_W'(IDLE_TIMEOUT)) ? timer_q : timer_q + TMR_W'(1);
   end

   assign drain_cond = (count_d >= CNT_W'(DRAIN_THRESH)) ||
                       (bus.flush_i && count_d != '0) ||
                       (IDLE_TIMEOUT > 0 && timer_d == TMR_W'(IDLE_TIMEOUT) && count_d != '0);

   // Next request is loaded from the post-update entry image, so a store merged into
   // the upcoming head in the same cycle is not lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_be_q    <= '0;
      end else if (state_q == IDLE || fire) begin
         if (drain_cond) begin
            state_q     <= REQ;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {wa_d[head_d], {OFF_W{1'b0}}};
            mem_data_q  <= data_d[head_d];
            mem_be_q    <= be_d[head_d];
         end else begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q   <= '0;
         wa_q    <= '0;
         data_q  <= '0;
         be_q    <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         timer_q <= '0;
      end else begin
         vld_q   <= vld_d;
         wa_q    <= wa_d;
         data_q  <= data_d;
         be_q    <= be_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         timer_q <= timer_d;
      end
   end

   assign bus.st_ready_o   = st_ready;
   assign bus.mem_valid_o  = mem_valid_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = mem_data_q;
   assign bus.mem_be_o     = mem_be_q;
   assign bus.ld_hit_o     = |ld_match;
   assign bus.flush_done_o = bus.flush_i && (count_q == '0);
   assign bus.count_o      = count_q;
endmodule

// File: tb/tb_wt_dcache_wbuf_coalesce.sv
// Bench for the coalescing write buffer: a coalescing and a non-coalescing instance share
// stimulus; each is compared every cycle against a queue model of the buffer contents.
module tb_wt_dcache_wbuf_coalesce;
   localparam int DEPTH = 4, DATA_W = 64, ADDR_W = 32, THRESH = 2, TMO = 8;

   typedef struct {
      logic [28:0] w;
      logic [63:0] d;
      logic [7:0]  be;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wt_dcache_wbuf_coalesce_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
   wt_dcache_wbuf_coalesce_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

   wt_dcache_wbuf_coalesce #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COALESCE_EN(1),
      .DRAIN_THRESH(THRESH), .IDLE_TIMEOUT(TMO)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
   wt_dcache_wbuf_coalesce #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COALESCE_EN(0),
      .DRAIN_THRESH(THRESH), .IDLE_TIMEOUT(TMO)) u_dut_nc (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

   logic        st_valid, mem_ready, flush;
   logic [31:0] st_addr, ld_addr;
   logic [63:0] st_data;
   logic [7:0]  st_be;

   ent_t mq [2][DEPTH];
   int   msz [2];
   bit   mreq [2];
   int   mtmr [2];
   int   n_tests = 0, n_fail = 0, cyc = 0;
   logic [31:0] log0 [$];
   logic [31:0] log1 [$];
   logic [7:0]  logbe1 [$];
   int          fcyc [$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] bemask(input logic [7:0] be);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
      return m;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         msz[k] = 0; mreq[k] = 0; mtmr[k] = 0;
      end
   endtask

   // One cycle of the buffer at transaction level: compare, then apply the clock edge.
   task automatic model_step(input int k, input logic rdy, input logic mv, input logic [31:0] ma,
                             input logic [63:0] md, input logic [7:0] mb, input logic lh,
                             input logic fd, input logic [2:0] cnt);
      int hi = -1;
      bit lhit = 0;
      bit exp_rdy, acc, fire;
      int pre;
      logic [63:0] m;
      logic [28:0] sw = st_addr[31:3];
      logic [28:0] lw = ld_addr[31:3];
      for (int i = 0; i < msz[k]; i++) begin
         if (k == 0 && !(i == 0 && mreq[k]) && mq[k][i].w == sw) hi = i;
         if (mq[k][i].w == lw) lhit = 1;
      end
      exp_rdy = !flush && (hi >= 0 || msz[k] < DEPTH);
      chk($sformatf("st_ready%0d", k), rdy, exp_rdy);
      chk($sformatf("count%0d", k), cnt, msz[k]);
      chk($sformatf("mem_valid%0d", k), mv, mreq[k]);
      chk($sformatf("ld_hit%0d", k), lh, lhit);
      chk($sformatf("flush_done%0d", k), fd, flush && msz[k] == 0);
      if (mreq[k]) begin
         m = bemask(mq[k][0].be);
         chk($sformatf("mem_addr%0d", k), ma, {mq[k][0].w, 3'b000});
         chk($sformatf("mem_be%0d", k), mb, mq[k][0].be);
         chk($sformatf("mem_data%0d", k), md & m, mq[k][0].d & m);
      end
      fire = mreq[k] && mem_ready;
      acc  = st_valid && exp_rdy;
      pre  = msz[k];
      if (acc && hi >= 0) begin
         m = bemask(st_be);
         mq[k][hi].d  = (mq[k][hi].d & ~m) | (st_data & m);
         mq[k][hi].be = mq[k][hi].be | st_be;
      end
      if (fire) begin
         for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
         msz[k]--;
      end
      if (acc && hi < 0) begin
         mq[k][msz[k]] = '{sw, st_data, st_be};
         msz[k]++;
      end
      if (acc || pre == 0) mtmr[k] = 0;
      else if (mtmr[k] < TMO) mtmr[k]++;
      if (!mreq[k] || fire)
         mreq[k] = (msz[k] >= THRESH) || (flush && msz[k] > 0) || (mtmr[k] == TMO && msz[k] > 0);
   endtask

   task automatic cycle();
      @(negedge clk);
      bus0.st_valid_i = st_valid; bus1.st_valid_i = st_valid;
      bus0.st_addr_i  = st_addr;  bus1.st_addr_i  = st_addr;
      bus0.st_data_i  = st_data;  bus1.st_data_i  = st_data;
      bus0.st_be_i    = st_be;    bus1.st_be_i    = st_be;
      bus0.mem_ready_i = mem_ready; bus1.mem_ready_i = mem_ready;
      bus0.ld_addr_i  = ld_addr;  bus1.ld_addr_i  = ld_addr;
      bus0.flush_i    = flush;    bus1.flush_i    = flush;
      #1;
      cyc++;
      if (rst_n) begin
         model_step(0, bus0.st_ready_o, bus0.mem_valid_o, bus0.mem_addr_o, bus0.mem_data_o,
                    bus0.mem_be_o, bus0.ld_hit_o, bus0.flush_done_o, bus0.count_o);
         model_step(1, bus1.st_ready_o, bus1.mem_valid_o, bus1.mem_addr_o, bus1.mem_data_o,
                    bus1.mem_be_o, bus1.ld_hit_o, bus1.flush_done_o, bus1.count_o);
         if (bus0.mem_valid_o && mem_ready) begin
            log0.push_back(bus0.mem_addr_o); fcyc.push_back(cyc);
         end
         if (bus1.mem_valid_o && mem_ready) begin
            log1.push_back(bus1.mem_addr_o); logbe1.push_back(bus1.mem_be_o);
         end
      end
   endtask

   task automatic st(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
      st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
      cycle();
      st_valid = 1'b0;
   endtask

   task automatic drain();
      st_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 40 && (bus0.count_o != 0 || bus1.count_o != 0 ||
                                 bus0.mem_valid_o || bus1.mem_valid_o); i++) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dens;
      st_valid = 0; mem_ready = 0; flush = 0; st_addr = 0; ld_addr = 0; st_data = 0; st_be = 0;
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
      chk("rst_count", bus0.count_o, 0);
      chk("rst_mem_valid", bus0.mem_valid_o, 0);
      chk("rst_mem_addr", bus0.mem_addr_o, 0);
      chk("rst_mem_data", bus0.mem_data_o, 0);
      chk("rst_mem_be", bus0.mem_be_o, 0);
      chk("rst_st_ready", bus0.st_ready_o, 1);

      // Two halves of one word merge, then drain via the idle timeout.
      mem_ready = 1'b1;
      st(32'h100, 64'h11111111_11111111, 8'h0F);
      st(32'h104, 64'h22222222_22222222, 8'hF0);
      cycle();
      chk("A_count", bus0.count_o, 1);
      for (int i = 0; i < 20 && !bus0.mem_valid_o; i++) cycle();
      chk("A_valid", bus0.mem_valid_o, 1);
      chk("A_addr", bus0.mem_addr_o, 32'h100);
      chk("A_be", bus0.mem_be_o, 8'hFF);
      chk("A_data", bus0.mem_data_o, 64'h22222222_11111111);
      drain();

      // Fill with memory stalled: full, coalesce still allowed, locked head refused.
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) st(32'(i * 8), {$urandom, $urandom}, 8'hFF);
      st_valid = 1'b1; st_addr = 32'h20; cycle();
      chk("B_count", bus0.count_o, 4);
      chk("B_full_ready", bus0.st_ready_o, 0);
      st_addr = 32'h8; cycle();
      chk("B_coal_ready", bus0.st_ready_o, 1);
      st_addr = 32'h0; cycle();
      chk("B_locked_ready", bus0.st_ready_o, 0);
      st_valid = 1'b0;

      // Stall-toggled drain keeps allocation order.
      log0.delete();
      for (int i = 0; i < 40 && (bus0.count_o != 0 || bus1.count_o != 0 ||
                                 bus0.mem_valid_o || bus1.mem_valid_o); i++) begin
         mem_ready = (i % 2 == 1); cycle();
      end
      chk("C_count", bus0.count_o, 0);
      chk("C_ndrain", log0.size(), 4);
      for (int i = 0; i < 4 && i < log0.size(); i++)
         chk($sformatf("C_order%0d", i), log0[i], 32'(i * 8));
      drain();

      // Non-coalescing instance keeps two entries for the same word.
      mem_ready = 1'b0; log1.delete(); logbe1.delete();
      st(32'h40, 64'h0000_0000_0000_A5A5, 8'h03);
      st(32'h40, 64'h0000_5A5A_0000_0000, 8'h30);
      cycle();
      chk("D_count_nc", bus1.count_o, 2);
      chk("D_count_c", bus0.count_o, 1);
      drain();
      chk("D_ndrain", log1.size(), 2);
      if (log1.size() == 2) begin
         chk("D_addr0", log1[0], 32'h40);
         chk("D_addr1", log1[1], 32'h40);
         chk("D_be0", logbe1[0], 8'h03);
         chk("D_be1", logbe1[1], 8'h30);
      end

      // Flush: stores blocked, three back-to-back drains, done when empty.
      mem_ready = 1'b0;
      st(32'h200, 64'h1, 8'hFF); st(32'h208, 64'h2, 8'hFF); st(32'h210, 64'h3, 8'hFF);
      cycle();
      log0.delete(); fcyc.delete();
      flush = 1'b1; mem_ready = 1'b1; st_valid = 1'b1; st_addr = 32'h300;
      cycle();
      chk("E_st_ready", bus0.st_ready_o, 0);
      for (int i = 0; i < 20 && !bus0.flush_done_o; i++) cycle();
      chk("E_flush_done", bus0.flush_done_o, 1);
      chk("E_count", bus0.count_o, 0);
      chk("E_ndrain", log0.size(), 3);
      if (fcyc.size() == 3) chk("E_b2b", fcyc[2] - fcyc[0], 2);
      flush = 1'b0; st_valid = 1'b0;
      drain();

      // Reset in the middle of a drain.
      mem_ready = 1'b0;
      st(32'h400, 64'h4, 8'hFF); st(32'h408, 64'h5, 8'hFF); st(32'h410, 64'h6, 8'hFF);
      cycle();
      chk("F_valid_pre", bus0.mem_valid_o, 1);
      rst_n = 1'b0;
      #1;
      chk("F_valid", bus0.mem_valid_o, 0);
      chk("F_count", bus0.count_o, 0);
      chk("F_count_nc", bus1.count_o, 0);
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;

      // Load probe matches on word address only.
      st(32'h108, 64'h7, 8'hFF);
      ld_addr = 32'h10C; cycle();
      chk("G_hit", bus0.ld_hit_o, 1);
      ld_addr = 32'h110; cycle();
      chk("G_miss", bus0.ld_hit_o, 0);
      drain();

      // Random traffic over a handful of words.
      dens = 5;
      for (int n = 0; n < 3000; n++) begin
         if (n % 100 == 0) dens = $urandom_range(0, 10);
         if ($urandom_range(0, 59) == 0) flush = ~flush;
         st_valid  = ($urandom_range(0, 9) < dens);
         st_addr   = 32'h1000 + 32'($urandom_range(0, 5) * 8) + 32'($urandom_range(0, 7));
         st_data   = {$urandom, $urandom};
         st_be     = 8'($urandom_range(1, 255));
         mem_ready = ($urandom_range(0, 3) != 0);
         ld_addr   = 32'h1000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
         cycle();
      end
      drain();
      chk("end_count", bus0.count_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
